// File: rtl/fluxo_dados_genius.sv
// fluxo_dados_genius: datapath of the memory-sequence game.
// Executes the controller's zera*/conta*/registra* strobes and returns status flags.
// Optional feature macro: GENIUS_TIMEOUT_EN (inter-play timeout counter; timeout tied 0 when undefined).
module fluxo_dados_genius #(
   parameter int TMR_CYC     = 1000,
   parameter int TIMEOUT_CYC = 5000,
   parameter int N_SEQ       = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       zeraE,
   input  logic       contaE,
   input  logic       zeraS,
   input  logic       contaS,
   input  logic       zeraTMR,
   input  logic       contaTMR,
   input  logic       zeraM,
   input  logic       registraM,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic       zeraL,
   output logic       jogada,
   output logic       igual,
   output logic       enderecoIgualSequencia,
   output logic       fimE,
   output logic       fimS,
   output logic       fimTMR,
   output logic       timeout,
   output logic [3:0] leds,
   output logic [3:0] db_endereco,
   output logic [3:0] db_sequencia,
   output logic [3:0] db_jogada
);

   localparam int              TMR_W    = $clog2(TMR_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_CYC - 1);
   localparam logic [3:0]       SEQ_LAST = 4'(N_SEQ - 1);

   // Reject configurations the 4-bit sequence counter or the counters cannot represent
   if (N_SEQ < 1 || N_SEQ > 16 || TMR_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("fluxo_dados_genius: invalid parameter set");
   end

   logic [3:0]       endereco;
   logic [3:0]       sequencia;
   logic [TMR_W-1:0] timer;
   logic [3:0]       play;
   logic [3:0]       rom_data;
   logic             prev;

   // Address counter: clear wins, natural 4-bit wrap at 15
   always_ff @(posedge clock) begin
      if (reset || zeraE)
         endereco <= '0;
      else if (contaE)
         endereco <= endereco + 4'd1;
   end

   // Round counter: clear wins, wraps after N_SEQ-1
   always_ff @(posedge clock) begin
      if (reset || zeraS)
         sequencia <= '0;
      else if (contaS)
         sequencia <= (sequencia == SEQ_LAST) ? '0 : sequencia + 4'd1;
   end

   // Display timer: clear wins, wraps after TMR_CYC-1
   always_ff @(posedge clock) begin
      if (reset || zeraTMR)
         timer <= '0;
      else if (contaTMR)
         timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
   end

   // Sequence ROM, one-hot LED patterns
   always_comb begin
      rom_data = 4'h1;
      case (endereco)
         4'd0:  rom_data = 4'h1;
         4'd1:  rom_data = 4'h2;
         4'd2:  rom_data = 4'h4;
         4'd3:  rom_data = 4'h8;
         4'd4:  rom_data = 4'h4;
         4'd5:  rom_data = 4'h2;
         4'd6:  rom_data = 4'h1;
         4'd7:  rom_data = 4'h1;
         4'd8:  rom_data = 4'h2;
         4'd9:  rom_data = 4'h2;
         4'd10: rom_data = 4'h4;
         4'd11: rom_data = 4'h4;
         4'd12: rom_data = 4'h8;
         4'd13: rom_data = 4'h8;
         4'd14: rom_data = 4'h1;
         4'd15: rom_data = 4'h4;
         default: rom_data = 4'h1;
      endcase
   end

   // LED register: clear wins over load
   always_ff @(posedge clock) begin
      if (reset || zeraM)
         leds <= '0;
      else if (registraM)
         leds <= rom_data;
   end

   // Play register: clear wins over capture of the buttons
   always_ff @(posedge clock) begin
      if (reset || zeraR)
         play <= '0;
      else if (registraR)
         play <= botoes;
   end

   // Edge detector history; forced high so a button already held gives no pulse
   always_ff @(posedge clock) begin
      if (reset || zeraL)
         prev <= 1'b1;
      else
         prev <= |botoes;
   end

`ifdef GENIUS_TIMEOUT_EN
   localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_cnt;

   // Inter-play timeout: any play-related activity restarts it, saturates at the limit
   always_ff @(posedge clock) begin
      if (reset || zeraE || contaE || registraR || zeraL)
         to_cnt <= '0;
      else if (to_cnt != TO_LAST)
         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (to_cnt == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   assign jogada                 = (|botoes) & ~prev;
   assign igual                  = (play == rom_data);
   assign enderecoIgualSequencia = (endereco == sequencia);
   assign fimE                   = (endereco == 4'd15);
   assign fimS                   = (sequencia == SEQ_LAST);
   assign fimTMR                 = (timer == TMR_LAST);
   assign db_endereco            = endereco;
   assign db_sequencia           = sequencia;
   assign db_jogada              = play;

endmodule

// File: tb/tb_fluxo_dados_genius.sv
// Directed bench for fluxo_dados_genius (TMR_CYC=10, TIMEOUT_CYC=20, N_SEQ=12).
module tb_fluxo_dados_genius;

   logic       clock = 1'b0;
   logic       reset, zeraE, contaE, zeraS, contaS, zeraTMR, contaTMR;
   logic       zeraM, registraM, zeraR, registraR, zeraL;
   logic [3:0] botoes;
   logic       jogada, igual, enderecoIgualSequencia, fimE, fimS, fimTMR, timeout;
   logic [3:0] leds, db_endereco, db_sequencia, db_jogada;

   int total = 0;
   int bad   = 0;

   fluxo_dados_genius #(.TMR_CYC(10), .TIMEOUT_CYC(20), .N_SEQ(12)) dut (
      .clock(clock), .reset(reset), .botoes(botoes),
      .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
      .zeraTMR(zeraTMR), .contaTMR(contaTMR), .zeraM(zeraM), .registraM(registraM),
      .zeraR(zeraR), .registraR(registraR), .zeraL(zeraL),
      .jogada(jogada), .igual(igual), .enderecoIgualSequencia(enderecoIgualSequencia),
      .fimE(fimE), .fimS(fimS), .fimTMR(fimTMR), .timeout(timeout), .leds(leds),
      .db_endereco(db_endereco), .db_sequencia(db_sequencia), .db_jogada(db_jogada)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ctl bit order: {zeraE, contaE, zeraS, contaS, zeraM, registraM, zeraR, registraR}
   // flg bit order: {igual, enderecoIgualSequencia, fimE, fimS}
   typedef struct {
      logic [7:0] ctl;
      logic [3:0] b;
      logic [3:0] e, s, l, p;
      logic [3:0] flg;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      {zeraE, contaE, zeraS, contaS, zeraTMR, contaTMR} = '0;
      {zeraM, registraM, zeraR, registraR, zeraL}       = '0;
   endtask

   initial begin
      vecs[0]  = '{8'b1010_1010, 4'h0, 4'd0, 4'd0, 4'h0, 4'h0, 4'b0100};
      vecs[1]  = '{8'b0100_0000, 4'h0, 4'd1, 4'd0, 4'h0, 4'h0, 4'b0000};
      vecs[2]  = '{8'b0100_0000, 4'h0, 4'd2, 4'd0, 4'h0, 4'h0, 4'b0000};
      vecs[3]  = '{8'b0100_0000, 4'h0, 4'd3, 4'd0, 4'h0, 4'h0, 4'b0000};
      vecs[4]  = '{8'b0000_0100, 4'h0, 4'd3, 4'd0, 4'h8, 4'h0, 4'b0000};
      vecs[5]  = '{8'b0000_1100, 4'h0, 4'd3, 4'd0, 4'h0, 4'h0, 4'b0000};
      vecs[6]  = '{8'b0100_0100, 4'h0, 4'd4, 4'd0, 4'h8, 4'h0, 4'b0000};
      vecs[7]  = '{8'b1100_0000, 4'h0, 4'd0, 4'd0, 4'h8, 4'h0, 4'b0100};
      vecs[8]  = '{8'b0100_0001, 4'h2, 4'd1, 4'd0, 4'h8, 4'h2, 4'b1000};
      vecs[9]  = '{8'b0001_0000, 4'h0, 4'd1, 4'd1, 4'h8, 4'h2, 4'b1100};
      vecs[10] = '{8'b0000_0001, 4'h4, 4'd1, 4'd1, 4'h8, 4'h4, 4'b0100};
      vecs[11] = '{8'b0000_0011, 4'h4, 4'd1, 4'd1, 4'h8, 4'h0, 4'b0100};
      vecs[12] = '{8'b0011_0000, 4'h0, 4'd1, 4'd0, 4'h8, 4'h0, 4'b0000};

      idle();
      botoes = 4'h0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_end", 32'(db_endereco), 32'h0);
      chk("rst_seq", 32'(db_sequencia), 32'h0);
      chk("rst_jogada", 32'(jogada), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_flags", 32'({fimTMR, fimE, fimS, enderecoIgualSequencia}), 32'b0001);

      // Table: strobes for one edge, then registered state and flags
      for (int i = 0; i < 13; i++) begin
         {zeraE, contaE, zeraS, contaS, zeraM, registraM, zeraR, registraR} = vecs[i].ctl;
         botoes = vecs[i].b;
         tick();
         chk($sformatf("vec%0d", i),
             32'({db_endereco, db_sequencia, leds, db_jogada,
                  igual, enderecoIgualSequencia, fimE, fimS}),
             32'({vecs[i].e, vecs[i].s, vecs[i].l, vecs[i].p, vecs[i].flg}));
      end
      idle();
      botoes = 4'h0;

      // Address counter wrap at 15
      zeraE = 1'b1;
      tick();
      zeraE  = 1'b0;
      contaE = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         chk($sformatf("addr_wrap%0d", n), 32'({fimE, db_endereco}),
             32'({(n == 15), 4'(n % 16)}));
      end
      contaE = 1'b0;

      // Round counter wrap at N_SEQ-1 = 11
      zeraS = 1'b1;
      tick();
      zeraS  = 1'b0;
      contaS = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         chk($sformatf("seq_wrap%0d", n), 32'({fimS, db_sequencia}),
             32'({(n == 11), 4'(n % 12)}));
      end
      contaS = 1'b0;

      // Display timer: fimTMR on count 9, wrap to 0; clear beats increment
      zeraTMR = 1'b1;
      tick();
      zeraTMR = 1'b0;
      chk("tmr_clr", 32'(fimTMR), 32'h0);
      contaTMR = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         chk($sformatf("tmr%0d", n), 32'(fimTMR), 32'((n % 10) == 9));
      end
      zeraTMR = 1'b1;
      tick();
      zeraTMR = 1'b0;
      chk("tmr_clr_prio", 32'(fimTMR), 32'h0);
      repeat (9) tick();
      chk("tmr_nine_after_clr", 32'(fimTMR), 32'h1);
      contaTMR = 1'b0;

      // Edge detector + play register at endereco=1
      zeraE = 1'b1;
      tick();
      zeraE  = 1'b0;
      contaE = 1'b1;
      tick();
      contaE = 1'b0;
      tick();
      botoes    = 4'h2;
      registraR = 1'b1;
      #1;
      chk("jog_press", 32'(jogada), 32'h1);
      tick();
      registraR = 1'b0;
      chk("jog_play", 32'({igual, db_jogada}), 32'({1'b1, 4'h2}));
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("jog_held%0d", n), 32'(jogada), 32'h0);
         tick();
      end
      botoes = 4'h0;
      tick();
      botoes = 4'h6;
      #1;
      chk("jog_two_btn", 32'(jogada), 32'h1);
      tick();
      chk("jog_two_held", 32'(jogada), 32'h0);
      botoes = 4'h0;
      tick();
      zeraL = 1'b1;
      tick();
      zeraL  = 1'b0;
      botoes = 4'h1;
      #1;
      chk("jog_after_zeraL", 32'(jogada), 32'h0);
      tick();
      chk("jog_after_zeraL2", 32'(jogada), 32'h0);
      botoes = 4'h0;
      tick();
      botoes = 4'h1;
      #1;
      chk("jog_repress", 32'(jogada), 32'h1);
      botoes = 4'h8;
      reset  = 1'b1;
      tick();
      reset = 1'b0;
      chk("jog_reset_held", 32'({jogada, leds, db_endereco}), 32'h0);
      botoes = 4'h0;

      // Timeout counter
      zeraE = 1'b1;
      tick();
      zeraE = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
      chk("to_clr", 32'(timeout), 32'h0);
      for (int n = 1; n <= 22; n++) begin
         tick();
         chk($sformatf("to_idle%0d", n), 32'(timeout), 32'(n >= 19));
      end
      contaE = 1'b1;
      tick();
      contaE = 1'b0;
      chk("to_contaE", 32'(timeout), 32'h0);
      repeat (19) tick();
      chk("to_again", 32'(timeout), 32'h1);
      registraR = 1'b1;
      tick();
      registraR = 1'b0;
      chk("to_registraR", 32'(timeout), 32'h0);
`else
      repeat (25) tick();
      chk("to_disabled", 32'(timeout), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
